// File: rtl/adc_cal_pkg.sv
// Shared types and default constants for the ADC offset calibration slice.
package adc_cal_pkg;

  // Calibration sequencer states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCUM     = 3'd1,
    UPDATE    = 3'd2,
    ROUND_END = 3'd3,
    DONE      = 3'd4
  } cal_state_e;

  // Default geometry of the interleaved converter and calibration loop
  localparam int DEF_ADC_WAYS   = 8;
  localparam int DEF_ADC_BITS   = 9;
  localparam int DEF_TRIM_BITS  = 8;
  localparam int DEF_ACC_LOG2   = 6;
  localparam int DEF_DEADBAND   = 2;
  localparam int DEF_MAX_ROUNDS = 64;

  // Width of the shared signed offset accumulator
  localparam int ACC_WIDTH = 16;

  // Mid-scale code of an unsigned converter of the given width
  function automatic int midCode(input int bits);
    return 1 << (bits - 1);
  endfunction

  localparam int MID_CODE = 256;

endpackage

// File: rtl/adc_os_acc.sv
// Shared offset accumulator and sample counter, reused for every way in turn.
module adc_os_acc
  import adc_cal_pkg::*;
#(
  parameter int SAMPLE_W = DEF_ADC_BITS + 1,
  parameter int ACC_LOG2 = DEF_ACC_LOG2
) (
  input  logic                        clock,
  input  logic                        clkrstP_s2,
  input  logic                        clear_i,
  input  logic                        add_i,
  input  logic signed [SAMPLE_W-1:0]  sample_i,
  output logic                        last_o,
  output logic                        full_o,
  output logic signed [ACC_WIDTH-1:0] mean_o
);

  localparam int CNT_W = ACC_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1 << ACC_LOG2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << ACC_LOG2) - 1);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic signed [ACC_WIDTH-1:0] sampleExt;

  assign sampleExt = $signed({{(ACC_WIDTH-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i});
  assign full_o    = (count_q == FULL_CNT);
  assign last_o    = (count_q == LAST_CNT);
  assign mean_o    = acc_q >>> ACC_LOG2;

  // Clear wins over add; a full window ignores further samples
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (clear_i) begin
      acc_d   = '0;
      count_d = '0;
    end else if (add_i && !full_o) begin
      acc_d   = acc_q + sampleExt;
      count_d = count_q + CNT_W'(1);
    end
  end

  // Accumulator and counter registers with asynchronous reset
  always_ff @(posedge clock or posedge clkrstP_s2) begin
    if (clkrstP_s2) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/adc_os_cal.sv
// Foreground offset calibration for a time-interleaved ADC: measures each way's
// mean offset and nudges its osp/osm trim pair one step per round.
module adc_os_cal
  import adc_cal_pkg::*;
#(
  parameter int ADC_WAYS   = DEF_ADC_WAYS,
  parameter int ADC_BITS   = DEF_ADC_BITS,
  parameter int TRIM_BITS  = DEF_TRIM_BITS,
  parameter int ACC_LOG2   = DEF_ACC_LOG2,
  parameter int DEADBAND   = DEF_DEADBAND,
  parameter int MAX_ROUNDS = DEF_MAX_ROUNDS
) (
  input  logic                          clock,
  input  logic                          clkrstP_s2,
  input  logic                          cal_en,
  input  logic                          din_valid,
  input  logic [ADC_WAYS*ADC_BITS-1:0]  adc_codes,
  output logic [ADC_WAYS*TRIM_BITS-1:0] osp_trim,
  output logic [ADC_WAYS*TRIM_BITS-1:0] osm_trim,
  output logic                          cal_busy,
  output logic                          cal_done,
  output logic                          cal_fail
);

  localparam int SAMPLE_W = ADC_BITS + 1;
  localparam int WAY_W    = (ADC_WAYS > 1) ? $clog2(ADC_WAYS) : 1;
  localparam int ROUND_W  = $clog2(MAX_ROUNDS + 1);

  localparam logic [WAY_W-1:0]           WAY_LAST   = WAY_W'(ADC_WAYS - 1);
  localparam logic [ROUND_W-1:0]         ROUND_LAST = ROUND_W'(MAX_ROUNDS - 1);
  localparam logic [TRIM_BITS-1:0]       TRIM_MAX   = '1;
  localparam logic signed [SAMPLE_W-1:0] MID        = SAMPLE_W'(midCode(ADC_BITS));
  localparam logic signed [ACC_WIDTH-1:0] DB_POS    = ACC_WIDTH'(DEADBAND);
  localparam logic signed [ACC_WIDTH-1:0] DB_NEG    = -DB_POS;

  cal_state_e           state_q, state_d;
  logic [WAY_W-1:0]     way_q, way_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic                 allConv_q, allConv_d;
  logic [TRIM_BITS-1:0] osp_q [ADC_WAYS];
  logic [TRIM_BITS-1:0] osp_d [ADC_WAYS];
  logic [TRIM_BITS-1:0] osm_q [ADC_WAYS];
  logic [TRIM_BITS-1:0] osm_d [ADC_WAYS];
  logic                 calBusy_q, calBusy_d;
  logic                 calDone_q, calDone_d;
  logic                 calFail_q, calFail_d;

  logic [ADC_BITS-1:0]         curCode;
  logic signed [SAMPLE_W-1:0]  curSample;
  logic                        accClear, accAdd, accLast, accFull;
  logic signed [ACC_WIDTH-1:0] accMean;
  logic                        adjust;

  assign curCode   = adc_codes[int'(way_q)*ADC_BITS +: ADC_BITS];
  assign curSample = $signed({1'b0, curCode}) - MID;

  // The window is only live while measuring; any other state or an abort empties it
  assign accClear = (state_q != ACCUM) || !cal_en;
  assign accAdd   = (state_q == ACCUM) && cal_en && din_valid;

  adc_os_acc #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_LOG2 (ACC_LOG2)
  ) u_acc (
    .clock      (clock),
    .clkrstP_s2 (clkrstP_s2),
    .clear_i    (accClear),
    .add_i      (accAdd),
    .sample_i   (curSample),
    .last_o     (accLast),
    .full_o     (accFull),
    .mean_o     (accMean)
  );

  // Step the current way's trim pair toward zero offset, draining the opposite side first
  always_comb begin
    osp_d  = osp_q;
    osm_d  = osm_q;
    adjust = 1'b0;
    if (state_q == UPDATE && cal_en) begin
      if (accMean > DB_POS) begin
        adjust = 1'b1;
        if (osp_q[way_q] != '0) begin
          osp_d[way_q] = osp_q[way_q] - TRIM_BITS'(1);
        end else if (osm_q[way_q] != TRIM_MAX) begin
          osm_d[way_q] = osm_q[way_q] + TRIM_BITS'(1);
        end
      end else if (accMean < DB_NEG) begin
        adjust = 1'b1;
        if (osm_q[way_q] != '0) begin
          osm_d[way_q] = osm_q[way_q] - TRIM_BITS'(1);
        end else if (osp_q[way_q] != TRIM_MAX) begin
          osp_d[way_q] = osp_q[way_q] + TRIM_BITS'(1);
        end
      end
    end
  end

  // Sequencer next state: walk the ways, then decide converge / retry / give up
  always_comb begin
    state_d   = state_q;
    way_d     = way_q;
    round_d   = round_q;
    allConv_d = allConv_q;
    unique case (state_q)
      IDLE: begin
        if (cal_en) begin
          state_d   = ACCUM;
          way_d     = '0;
          round_d   = '0;
          allConv_d = 1'b1;
        end
      end
      ACCUM: begin
        if (!cal_en) begin
          state_d = IDLE;
        end else if (accFull || (din_valid && accLast)) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (!cal_en) begin
          state_d = IDLE;
        end else begin
          if (adjust) begin
            allConv_d = 1'b0;
          end
          if (way_q == WAY_LAST) begin
            state_d = ROUND_END;
          end else begin
            way_d   = way_q + WAY_W'(1);
            state_d = ACCUM;
          end
        end
      end
      ROUND_END: begin
        if (!cal_en) begin
          state_d = IDLE;
        end else if (allConv_q) begin
          state_d = DONE;
        end else begin
          round_d = round_q + ROUND_W'(1);
          if (round_q == ROUND_LAST) begin
            state_d = DONE;
          end else begin
            state_d   = ACCUM;
            way_d     = '0;
            allConv_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (!cal_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags follow the upcoming state so they can be registered alongside it
  always_comb begin
    calBusy_d = (state_d != IDLE) && (state_d != DONE);
    calDone_d = (state_d == DONE);
    calFail_d = 1'b0;
    if (state_d == DONE) begin
      calFail_d = (state_q == DONE) ? calFail_q : !allConv_q;
    end
  end

  // All sequencer, trim and status registers; reset throws away every trim
  always_ff @(posedge clock or posedge clkrstP_s2) begin
    if (clkrstP_s2) begin
      state_q   <= IDLE;
      way_q     <= '0;
      round_q   <= '0;
      allConv_q <= 1'b1;
      osp_q     <= '{default: '0};
      osm_q     <= '{default: '0};
      calBusy_q <= 1'b0;
      calDone_q <= 1'b0;
      calFail_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      way_q     <= way_d;
      round_q   <= round_d;
      allConv_q <= allConv_d;
      osp_q     <= osp_d;
      osm_q     <= osm_d;
      calBusy_q <= calBusy_d;
      calDone_q <= calDone_d;
      calFail_q <= calFail_d;
    end
  end

  for (genvar k = 0; k < ADC_WAYS; k++) begin : g_pack
    assign osp_trim[k*TRIM_BITS +: TRIM_BITS] = osp_q[k];
    assign osm_trim[k*TRIM_BITS +: TRIM_BITS] = osm_q[k];
  end

  assign cal_busy = calBusy_q;
  assign cal_done = calDone_q;
  assign cal_fail = calFail_q;

endmodule
